if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 79 +++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with hold register and redirect handling.
// Define FETCH_SKID_BUF_EN to add a 1-entry skid buffer behind the hold register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ready,
   input  logic [31:0] im_rdata,
   output logic        im_stall,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        CSR_interrupt,
   input  logic [31:0] mtvec,
   input  logic        CSR_ret,
   input  logic [31:0] mepc,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_flush
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`ifdef FETCH_SKID_BUF_EN
   localparam logic [1:0] CAP = 2'd2;
`else
   localparam logic [1:0] CAP = 2'd1;
`endif
   state_t state, state_nx;
   logic [31:0] pc, target;
   logic [1:0] n, n_nx;
   logic [63:0] q0, q1, q0_nx, q1_nx, ent0, ent1, in_w;
   logic redir, in_v, pop, flush_q;
   assign redir = CSR_interrupt | CSR_ret | redirect;
   assign target = (CSR_interrupt ? mtvec : CSR_ret ? mepc : redirect_pc) & ~32'h3;
   assign im_addr = pc;
   assign im_stall = im_req & ~im_ready;
   assign if_flush = flush_q | redir;
   // Buffered words (hold, then skid) form a tiny queue; the incoming word joins at the tail.
   assign in_w = {pc, im_rdata};
   assign in_v = im_req & im_ready & ~redir;
   assign pop = ~stall_in & ((n != 2'd0) | in_v);
   always_comb begin
      ent0 = (n != 2'd0) ? q0 : in_w;
      ent1 = (n == 2'd2) ? q1 : in_w;
      n_nx = n + {1'b0, in_v} - {1'b0, pop};
      q0_nx = pop ? ent1 : ent0;
      q1_nx = pop ? in_w : ent1;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      im_req = state == FETCH;
      state_nx = (redir || n_nx != CAP) ? FETCH : HOLD;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pc <= RESET_PC & ~32'h3;
         n <= 2'd0;
         q0 <= 64'h0;
         q1 <= 64'h0;
         if_pc <= 32'h0;
         if_instr <= 32'h0;
         flush_q <= 1'b1;
      end else if (redir) begin
         pc <= target;
         n <= 2'd0;
         flush_q <= 1'b1;
      end else begin
         if (in_v) pc <= pc + 32'd4;
         n <= n_nx;
         q0 <= q0_nx;
         q1 <= q1_nx;
         if (pop) {if_pc, if_instr} <= ent0;
         if (!stall_in) flush_q <= ~pop;
      end
endmodule
